// File: rtl/isr_pkg.sv
// ---------------------------------------------------------------------------
// isr_pkg : shared types and helpers for the streaming integer square root
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package isr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } isr_state_t;

  // Accept edge to first out_valid: one ISSUE + STAGES waits + one COMPARE per root bit.
  function automatic int isr_latency(input int in_w, input int stages);
    return (in_w / 2) * (stages + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/isr_stream_mult_pipe.sv
// ---------------------------------------------------------------------------
// mult_pipe : unsigned WIDTHxWIDTH multiplier, STAGES registers deep
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mult_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]     prod_q [STAGES];
  logic [STAGES-1:0] vld_q;

  // Data stages carry no reset; only the valid pipe needs flushing on abort.
  always_ff @(posedge clock) begin
    prod_q[0] <= PW'(a) * PW'(b);
    for (int k = 1; k < STAGES; k++) begin
      prod_q[k] <= prod_q[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= (vld_q << 1) | STAGES'(start);
    end
  end

  assign product = prod_q[STAGES-1];
  assign done    = vld_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/isr_stream.sv
// ---------------------------------------------------------------------------
// isr_stream : bit-serial integer square root with valid/ready streaming
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module isr_stream
  import isr_pkg::*;
#(
  parameter  int IN_WIDTH    = 64,
  parameter  int MULT_STAGES = 8,
  localparam int OUT_WIDTH   = IN_WIDTH / 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] result,
  output logic [OUT_WIDTH:0]   remainder,
  output logic                 busy
);

  localparam int IW      = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int LATENCY = isr_latency(IN_WIDTH, MULT_STAGES);

  isr_state_t           state_q, state_d;
  logic [IN_WIDTH-1:0]  val_q, val_d;
  logic [OUT_WIDTH-1:0] root_q, root_d;
  // remainder never exceeds 2*root, so only the low OUT_WIDTH+1 bits of the best square matter
  logic [OUT_WIDTH:0]   best_sq_q, best_sq_d;
  logic [IW-1:0]        idx_q, idx_d;

  logic [OUT_WIDTH-1:0] trial;
  logic [IN_WIDTH-1:0]  trial_sq;
  logic                 mult_start;
  logic                 mult_done;
  logic                 accept;

  assign trial = root_q | (OUT_WIDTH'(1) << idx_q);

  mult_pipe #(
    .WIDTH  (OUT_WIDTH),
    .STAGES (MULT_STAGES)
  ) u_mult (
    .clock   (clock),
    .reset   (reset),
    .start   (mult_start),
    .a       (trial),
    .b       (trial),
    .product (trial_sq),
    .done    (mult_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      val_q     <= '0;
      root_q    <= '0;
      best_sq_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      root_q    <= root_d;
      best_sq_q <= best_sq_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    root_d     = root_q;
    best_sq_d  = best_sq_q;
    idx_d      = idx_q;
    mult_start = 1'b0;
    in_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      ISSUE: begin
        mult_start = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (mult_done) begin
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (trial_sq <= val_q) begin
          root_d    = trial;
          best_sq_d = trial_sq[OUT_WIDTH:0];
        end
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = ISSUE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accept = in_valid && in_ready;
    if (accept) begin
      val_d     = value;
      root_d    = '0;
      best_sq_d = '0;
      idx_d     = IW'(OUT_WIDTH - 1);
      state_d   = ISSUE;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ISSUE) || (state_q == WAIT) || (state_q == COMPARE);
  assign result    = out_valid ? root_q : '0;
  assign remainder = out_valid ? (val_q[OUT_WIDTH:0] - best_sq_q) : '0;

  int lat_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      lat_cnt_q <= 0;
    end else if (accept) begin
      lat_cnt_q <= 1;
    end else if (busy) begin
      lat_cnt_q <= lat_cnt_q + 1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && state_q == COMPARE && state_d == DONE) begin
      assert (lat_cnt_q == LATENCY)
        else $error("isr_stream latency %0d, expected %0d", lat_cnt_q, LATENCY);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_isr_stream.sv
// ---------------------------------------------------------------------------
// tb_isr_stream : directed and property checks for isr_stream (64/8 and 16/1)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_isr_stream;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] value;
  logic [31:0] result;
  logic [32:0] remainder;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] value16;
  logic [7:0]  result16;
  logic [8:0]  remainder16;

  int n_cmp;
  int n_bad;

  isr_stream #(.IN_WIDTH(64), .MULT_STAGES(8)) u_dut (
    .clock(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .value(value),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .remainder(remainder), .busy(busy)
  );

  isr_stream #(.IN_WIDTH(16), .MULT_STAGES(1)) u_dut16 (
    .clock(clk), .reset(reset),
    .in_valid(in_valid16), .in_ready(in_ready16), .value(value16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .remainder(remainder16), .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op64(input logic [63:0] v, output logic [31:0] r,
                      output logic [32:0] rm, output int lat);
    int n;
    n = 0;
    in_valid = 1'b1;
    value    = v;
    while (!in_ready && n < 2000) begin tick(); n++; end
    check("accept64", in_ready, 1);
    tick();
    in_valid = 1'b0;
    value    = ~v;
    lat = 0;
    while (!out_valid && lat < 2000) begin tick(); lat++; end
    r  = result;
    rm = remainder;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic op16(input logic [15:0] v, output logic [7:0] r,
                      output logic [8:0] rm, output int lat);
    int n;
    n = 0;
    in_valid16 = 1'b1;
    value16    = v;
    while (!in_ready16 && n < 2000) begin tick(); n++; end
    check("accept16", in_ready16, 1);
    tick();
    in_valid16 = 1'b0;
    value16    = ~v;
    lat = 0;
    while (!out_valid16 && lat < 2000) begin tick(); lat++; end
    r  = result16;
    rm = remainder16;
    out_ready16 = 1'b1;
    tick();
    out_ready16 = 1'b0;
  endtask

  typedef struct {
    logic [63:0] v;
    logic [31:0] r;
    logic [32:0] rem;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0]  r;
    logic [32:0]  rm;
    logic [7:0]   r8;
    logic [8:0]   rm8;
    logic [63:0]  v;
    logic [15:0]  v16;
    logic [127:0] sq, sq1;
    int           lat;
    logic         ok;

    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    in_valid = 1'b0; value = '0; out_ready = 1'b0;
    in_valid16 = 1'b0; value16 = '0; out_ready16 = 1'b0;

    vecs = '{
      '{64'd0,                  32'd0,          33'd0},
      '{64'hFFFFFFFFFFFFFFFF,   32'hFFFFFFFF,   33'd8589934590},
      '{64'hFFFFFFFE00000001,   32'hFFFFFFFF,   33'd0},
      '{64'hFFFFFFFE00000000,   32'hFFFFFFFE,   33'd8589934588},
      '{64'd1,                  32'd1,          33'd0},
      '{64'd2,                  32'd1,          33'd1},
      '{64'd4567,               32'd67,         33'd78},
      '{64'd32768,              32'd181,        33'd7}
    };

    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    for (int k = 0; k < 8; k++) begin
      op64(vecs[k].v, r, rm, lat);
      check($sformatf("vec%0d_result", k), r, vecs[k].r);
      check($sformatf("vec%0d_remainder", k), rm, vecs[k].rem);
      check($sformatf("vec%0d_latency", k), lat, 320);
    end

    // Hold the result with out_ready low while offering (ignored) new input
    in_valid = 1'b1;
    value    = 64'hFFFFFFFE00000000;
    tick();
    value = 64'd5;
    lat = 0;
    while (!out_valid && lat < 2000) begin tick(); lat++; end
    check("hold_latency", lat, 320);
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!out_valid || in_ready || result !== 32'hFFFFFFFE || remainder !== 33'd8589934588)
        ok = 1'b0;
      tick();
    end
    check("hold_stable", ok, 1);
    check("hold_result", result, 32'hFFFFFFFE);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release_valid", out_valid, 0);
    check("hold_release_ready", in_ready, 1);
    check("hold_release_busy", busy, 0);

    // Back-to-back with in_valid held
    in_valid  = 1'b1;
    value     = 64'd4567;
    out_ready = 1'b1;
    tick();
    value = 64'd343396;
    lat = 0;
    while (!out_valid && lat < 2000) begin tick(); lat++; end
    check("b2b_first_latency", lat, 320);
    check("b2b_first_result", result, 67);
    check("b2b_first_remainder", remainder, 78);
    check("b2b_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("b2b_no_bubble_valid", out_valid, 0);
    check("b2b_no_bubble_busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 2000) begin tick(); lat++; end
    check("b2b_second_latency", lat, 320);
    check("b2b_second_result", result, 586);
    check("b2b_second_remainder", remainder, 0);
    tick();
    out_ready = 1'b0;
    check("b2b_drain", out_valid, 0);

    // Abort mid-computation
    in_valid = 1'b1;
    value    = 64'd32768;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    op64(64'd16383, r, rm, lat);
    check("abort_next_result", r, 127);
    check("abort_next_remainder", rm, 254);
    check("abort_next_latency", lat, 320);

    // Narrow configuration
    op16(16'd65535, r8, rm8, lat);
    check("w16_max_result", r8, 255);
    check("w16_max_remainder", rm8, 510);
    check("w16_latency", lat, 24);
    op16(16'd0, r8, rm8, lat);
    check("w16_zero_result", r8, 0);
    check("w16_zero_remainder", rm8, 0);

    for (int k = 0; k < 24; k++) begin
      v16 = 16'($urandom_range(0, 65535));
      op16(v16, r8, rm8, lat);
      sq  = {120'b0, r8} * {120'b0, r8};
      sq1 = ({120'b0, r8} + 128'd1) * ({120'b0, r8} + 128'd1);
      check($sformatf("rand16_%0d_lo v=%0d r=%0d", k, v16, r8), sq <= {112'b0, v16}, 1);
      check($sformatf("rand16_%0d_hi v=%0d r=%0d", k, v16, r8), {112'b0, v16} < sq1, 1);
      check($sformatf("rand16_%0d_rem", k), rm8, {112'b0, v16} - sq);
    end

    for (int k = 0; k < 6; k++) begin
      v = {32'($urandom()), 32'($urandom())};
      if (k == 0) v = v >> 40;
      op64(v, r, rm, lat);
      sq  = {96'b0, r} * {96'b0, r};
      sq1 = ({96'b0, r} + 128'd1) * ({96'b0, r} + 128'd1);
      check($sformatf("rand64_%0d_lo v=%0d r=%0d", k, v, r), sq <= {64'b0, v}, 1);
      check($sformatf("rand64_%0d_hi v=%0d r=%0d", k, v, r), {64'b0, v} < sq1, 1);
      check($sformatf("rand64_%0d_rem", k), rm, {64'b0, v} - sq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
